// File: rtl/anti_droop_pkg.sv
// Shared types and helpers for the multi-channel anti-droop IIR corrector.
package anti_droop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic int sat_dw(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/anti_droop_chan.sv
// One anti-droop channel: weighted integrator, scaled correction added to the
// delayed sample, saturate/wrap/bypass output select and sticky overflow flag.
module anti_droop_chan
  import anti_droop_pkg::*;
#(
  parameter int DW        = 13,
  parameter int TW        = 7,
  parameter int ACC_W     = 48,
  parameter int IIR_SCALE = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic signed [TW-1:0] tw,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  input  logic                 sat_en,
  input  logic                 bypass,
  input  logic                 oflow_clr,
  output logic        [DW-1:0] dout,
  output logic                 oflow
);

  logic signed [DW-1:0]    din_d_q, din_d_d;
  logic signed [DW+TW-1:0] mult_q, mult_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [DW-1:0]    dout_q, dout_d;
  logic                    oflow_q, oflow_d;

  logic signed [DW-1:0]             corr;
  logic signed [DW:0]               sum;
  logic [ACC_W-IIR_SCALE-DW:0]      top_bits;
  logic                             ovf_cond;

  always_comb begin
    din_d_d = din;
    mult_d  = (DW+TW)'(din) * (DW+TW)'(tw);

    // Clear beats accumulate so a retrigger starts the window from zero.
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + {{(ACC_W-DW-TW){mult_q[DW+TW-1]}}, mult_q};
    end

    corr = acc_q[IIR_SCALE+DW-1:IIR_SCALE];
    sum  = {din_d_q[DW-1], din_d_q} + {corr[DW-1], corr};

    if (bypass) begin
      dout_d = din_d_q;
    end else if (sat_en) begin
      dout_d = DW'(sat_dw(int'(sum), DW));
    end else begin
      dout_d = sum[DW-1:0];
    end

    // Scaled accumulator no longer fits the sample width when its upper bits disagree.
    top_bits = acc_q[ACC_W-1:IIR_SCALE+DW-1];
    ovf_cond = !((&top_bits) || (~|top_bits));
    oflow_d  = ovf_cond | (oflow_q & ~oflow_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_d_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      din_d_q <= din_d_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      oflow_q <= oflow_d;
    end
  end

  assign dout  = dout_q;
  assign oflow = oflow_q;

endmodule

// File: rtl/anti_droop_iir_mc.sv
// Multi-channel anti-droop corrector top: trigger edge detect, weight staging,
// shared accumulation-window FSM and NCH channel instances.
module anti_droop_iir_mc
  import anti_droop_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DW        = 13,
  parameter int TW        = 7,
  parameter int ACC_W     = 48,
  parameter int IIR_SCALE = 15,
  parameter int CW        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH*TW-1:0] tap_weight,
  input  logic [CW-1:0]     win_len,
  input  logic              acc_clr_en,
  input  logic              sat_en,
  input  logic              bypass,
  input  logic              oflow_clr,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    oflow,
  output logic              active,
  output logic [1:0]        dbg_state
);

  logic              trig_a_q, trig_a_d;
  logic              trig_b_q, trig_b_d;
  logic [NCH*TW-1:0] tw_a_q, tw_a_d;
  logic [NCH*TW-1:0] tw_b_q, tw_b_d;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic trig_edge;
  logic acc_en;
  logic acc_clr;

  always_comb begin
    trig_a_d  = trig;
    trig_b_d  = trig_a_q;
    tw_a_d    = tap_weight;
    tw_b_d    = tw_a_q;
    trig_edge = trig_a_q & ~trig_b_q;
    acc_en    = (state_q == ST_ACTIVE);
    acc_clr   = trig_edge & acc_clr_en;
  end

  // A loaded count of zero means an unlimited window; it never reaches HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          state_d = ST_ACTIVE;
          cnt_d   = win_len;
        end
      end
      ST_ACTIVE: begin
        if (trig_edge) begin
          cnt_d = win_len;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (trig_edge) begin
          state_d = ST_ACTIVE;
          cnt_d   = win_len;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_a_q <= 1'b0;
      trig_b_q <= 1'b0;
      tw_a_q   <= '0;
      tw_b_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      trig_a_q <= trig_a_d;
      trig_b_q <= trig_b_d;
      tw_a_q   <= tw_a_d;
      tw_b_q   <= tw_b_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active    = (state_q == ST_ACTIVE);
  assign dbg_state = state_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    anti_droop_chan #(
      .DW        (DW),
      .TW        (TW),
      .ACC_W     (ACC_W),
      .IIR_SCALE (IIR_SCALE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .din       (din[c*DW +: DW]),
      .tw        (tw_b_q[c*TW +: TW]),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .sat_en    (sat_en),
      .bypass    (bypass),
      .oflow_clr (oflow_clr),
      .dout      (dout[c*DW +: DW]),
      .oflow     (oflow[c])
    );
  end

endmodule

// File: tb/tb_anti_droop_iir_mc.sv
// Directed bench for anti_droop_iir_mc: expectations are queued with a target
// cycle and checked by an independent negedge monitor.
module tb_anti_droop_iir_mc;

  localparam int NCH       = 2;
  localparam int DW        = 13;
  localparam int TW        = 7;
  localparam int ACC_W     = 48;
  localparam int IIR_SCALE = 15;
  localparam int CW        = 16;

  localparam int ID_DOUT0  = 0;
  localparam int ID_DOUT1  = 1;
  localparam int ID_OFLOW  = 2;
  localparam int ID_ACTIVE = 3;
  localparam int ID_STATE  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              trig;
  logic [NCH*DW-1:0] din;
  logic [NCH*TW-1:0] tap_weight;
  logic [CW-1:0]     win_len;
  logic              acc_clr_en;
  logic              sat_en;
  logic              bypass;
  logic              oflow_clr;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    oflow;
  logic              active;
  logic [1:0]        dbg_state;

  anti_droop_iir_mc #(
    .NCH(NCH), .DW(DW), .TW(TW), .ACC_W(ACC_W), .IIR_SCALE(IIR_SCALE), .CW(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .din        (din),
    .tap_weight (tap_weight),
    .win_len    (win_len),
    .acc_clr_en (acc_clr_en),
    .sat_en     (sat_en),
    .bypass     (bypass),
    .oflow_clr  (oflow_clr),
    .dout       (dout),
    .oflow      (oflow),
    .active     (active),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // entry = {target cycle[31:0], id[7:0], expected value[31:0]}
  logic [71:0] exp_q[$];

  function automatic string id_name(input int id);
    case (id)
      ID_DOUT0:  return "dout0";
      ID_DOUT1:  return "dout1";
      ID_OFLOW:  return "oflow";
      ID_ACTIVE: return "active";
      default:   return "state";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int id);
    case (id)
      ID_DOUT0:  return {19'b0, dout[DW-1:0]};
      ID_DOUT1:  return {19'b0, dout[2*DW-1:DW]};
      ID_OFLOW:  return {30'b0, oflow};
      ID_ACTIVE: return {31'b0, active};
      default:   return {30'b0, dbg_state};
    endcase
  endfunction

  always @(negedge clk) begin
    int          i;
    int          tgt;
    int          id;
    logic [71:0] e;
    logic [31:0] v;
    logic [31:0] act;
    i = 0;
    while (i < exp_q.size()) begin
      e   = exp_q[i];
      tgt = int'(e[71:40]);
      id  = int'(e[39:32]);
      v   = e[31:0];
      if (tgt == cyc) begin
        act = actual(id);
        checks++;
        if (act !== v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", id_name(id), cyc, act, v);
        end
        exp_q.delete(i);
      end else if (tgt < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s overdue target=%0d now=%0d", id_name(id), tgt, cyc);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int id, input int val);
    logic [31:0] v;
    v = val;
    if (id == ID_DOUT0 || id == ID_DOUT1) v = v & 32'h1fff;
    exp_q.push_back({32'(cyc + dly), 8'(id), v});
  endtask

  task automatic set_ch(input int c, input int d, input int w);
    din[c*DW +: DW]        = DW'(d);
    tap_weight[c*TW +: TW] = TW'(w);
  endtask

  task automatic expect_all_zero();
    expect_at(0, ID_DOUT0, 0);
    expect_at(0, ID_DOUT1, 0);
    expect_at(0, ID_OFLOW, 0);
    expect_at(0, ID_ACTIVE, 0);
    expect_at(0, ID_STATE, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int guard;
    rst        = 1'b1;
    trig       = 1'b0;
    din        = '0;
    tap_weight = '0;
    win_len    = '0;
    acc_clr_en = 1'b0;
    sat_en     = 1'b0;
    bypass     = 1'b0;
    oflow_clr  = 1'b0;

    // Reset values
    tick(3);
    expect_all_zero();

    // Plain pass-through with no trigger
    tick(1);
    rst = 1'b0;
    set_ch(0, 100, 0);
    set_ch(1, 0, 0);
    expect_at(2, ID_DOUT0, 100);
    expect_at(10, ID_DOUT0, 100);
    expect_at(10, ID_ACTIVE, 0);
    expect_at(10, ID_OFLOW, 0);
    tick(12);

    // Unlimited window, independent channel weights
    set_ch(0, 1000, 63);
    set_ch(1, 1000, -64);
    win_len    = 16'd0;
    acc_clr_en = 1'b1;
    tick(5);
    trig = 1'b1;
    expect_at(1, ID_ACTIVE, 0);
    expect_at(2, ID_ACTIVE, 1);
    expect_at(102, ID_DOUT0, 1190);
    expect_at(102, ID_DOUT1, 806);
    expect_at(103, ID_DOUT0, 1192);
    expect_at(103, ID_DOUT1, 804);
    tick(3);
    trig = 1'b0;
    tick(101);

    // Asynchronous reset mid-window, checked before any clock edge
    #2;
    expect_all_zero();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_at(6, ID_DOUT0, 1000);
    expect_at(6, ID_DOUT1, 1000);
    expect_at(6, ID_ACTIVE, 0);
    tick(8);

    // Four-cycle window then HOLD, plus bypass in HOLD
    win_len = 16'd4;
    trig    = 1'b1;
    expect_at(1, ID_ACTIVE, 0);
    expect_at(2, ID_ACTIVE, 1);
    expect_at(3, ID_ACTIVE, 1);
    expect_at(4, ID_ACTIVE, 1);
    expect_at(5, ID_ACTIVE, 1);
    expect_at(6, ID_ACTIVE, 0);
    expect_at(6, ID_STATE, 2);
    expect_at(6, ID_DOUT0, 1005);
    expect_at(7, ID_DOUT0, 1007);
    expect_at(20, ID_DOUT0, 1007);
    expect_at(20, ID_DOUT1, 992);
    tick(2);
    trig = 1'b0;
    tick(18);
    bypass = 1'b1;
    expect_at(1, ID_DOUT0, 1000);
    tick(1);
    bypass = 1'b0;
    expect_at(1, ID_DOUT0, 1007);
    tick(3);

    // Retrigger mid-window with clear
    acc_clr_en = 1'b1;
    win_len    = 16'd10;
    trig       = 1'b1;
    expect_at(7, ID_DOUT0, 1007);
    expect_at(8, ID_DOUT0, 1000);
    expect_at(16, ID_ACTIVE, 1);
    expect_at(17, ID_ACTIVE, 0);
    expect_at(18, ID_DOUT0, 1019);
    tick(2);
    trig = 1'b0;
    tick(3);
    trig = 1'b1;
    tick(15);
    trig = 1'b0;
    tick(3);

    // Retrigger mid-window without clear: accumulator retained, count reloaded
    acc_clr_en = 1'b0;
    win_len    = 16'd4;
    trig       = 1'b1;
    expect_at(8, ID_ACTIVE, 1);
    expect_at(9, ID_ACTIVE, 0);
    expect_at(10, ID_DOUT0, 1032);
    expect_at(12, ID_DOUT1, 966);
    expect_at(13, ID_DOUT0, 1032);
    tick(2);
    trig = 1'b0;
    tick(1);
    trig = 1'b1;
    tick(11);
    trig = 1'b0;
    tick(3);

    // Overflow, saturate versus wrap, sticky flag clearing
    rst = 1'b1;
    set_ch(0, 4000, 63);
    set_ch(1, 0, 0);
    win_len    = 16'd0;
    acc_clr_en = 1'b1;
    sat_en     = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    trig = 1'b1;
    t = cyc;
    expect_at(203, ID_DOUT0, 4095);
    expect_at(204, ID_DOUT0, -2647);
    expect_at(205, ID_DOUT0, 4095);
    expect_at(535, ID_OFLOW, 0);
    expect_at(536, ID_OFLOW, 1);
    expect_at(543, ID_OFLOW, 1);
    expect_at(552, ID_OFLOW, 1);
    expect_at(553, ID_OFLOW, 0);
    tick(3);
    trig = 1'b0;
    tick(200);
    sat_en = 1'b0;
    tick(1);
    sat_en = 1'b1;
    tick(336);
    oflow_clr = 1'b1;
    tick(4);
    oflow_clr = 1'b0;
    tick(3);
    trig = 1'b1;
    tick(5);
    oflow_clr = 1'b1;
    tick(1);
    oflow_clr = 1'b0;
    trig      = 1'b0;
    if (cyc != t + 553) begin
      checks++;
      errors++;
      $display("FAIL sequencing cyc=%0d exp=%0d", cyc, t + 553);
    end

    // Drain outstanding expectations within a bounded wait
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain unchecked entry for id=%0d", int'(exp_q[0][39:32]));
      void'(exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
